vga_bounce_box: RTL and testbench

Pixel-stage renderer driven by the VGA timing generator in the pixel clock domain. It takes the horizontal/vertical counters, the active-area flag and the sync levels, and draws a solid box on black that moves one pixel per frame in each axis and bounces off the screen edges. The box changes colour on every bounce. Syncs are delayed to stay aligned with the registered colour outputs, and the results drive the 1-bit RGB pins directly.

---
 rtl/vga_bounce_box.sv | 170 +++++++++++++++++
 tb/tb_vga_bounce_box.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_box.sv
// vga_bounce_box: draws a solid box on black that moves one pixel per frame
// in each axis, bounces off the screen edges and changes colour on every
// bounce. Colour and sync outputs share a 2-cycle pipeline so they stay aligned.
// Optional feature macro: BOUNCE_PAUSE_EN adds i_pause, which freezes motion
// while still letting o_frame pulse.
module vga_bounce_box #(
  parameter int HPIX  = 640,
  parameter int VPIX  = 480,
  parameter int BOX_W = 32,
  parameter int BOX_H = 32
) (
  input  logic        i_pixclock,
  input  logic        i_reset,
  input  logic [11:0] i_hcount,
  input  logic [11:0] i_vcount,
  input  logic        i_enable,
  input  logic        i_hsync,
  input  logic        i_vsync,
`ifdef BOUNCE_PAUSE_EN
  input  logic        i_pause,
`endif
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_red,
  output logic        o_green,
  output logic        o_blue,
  output logic        o_frame
);

  localparam logic [11:0] X_MAX   = 12'(HPIX - BOX_W);
  localparam logic [11:0] Y_MAX   = 12'(VPIX - BOX_H);
  localparam logic [11:0] V_EVT   = 12'(VPIX);
  localparam logic [12:0] BOX_W13 = 13'(BOX_W);
  localparam logic [12:0] BOX_H13 = 13'(BOX_H);

  // Box state
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [2:0]  col_q, col_d;

  // Pipeline stage 1
  logic s1_inside_q, s1_inside_d;
  logic s1_hsync_q, s1_hsync_d;
  logic s1_vsync_q, s1_vsync_d;
  logic s1_event_q, s1_event_d;

  // Pipeline stage 2 (output registers)
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_q, frame_d;

  logic event_s, inside_s, pause_s, move_s, bounce_x_s, bounce_y_s;

`ifdef BOUNCE_PAUSE_EN
  assign pause_s = i_pause;
`else
  assign pause_s = 1'b0;
`endif

  // Decode the once-per-frame update event and the box hit test (13-bit bounds, no wrap)
  always_comb begin
    event_s  = (i_hcount == 12'd0) && (i_vcount == V_EVT);
    inside_s = ({1'b0, i_hcount} >= {1'b0, x_q}) &&
               ({1'b0, i_hcount} <  ({1'b0, x_q} + BOX_W13)) &&
               ({1'b0, i_vcount} >= {1'b0, y_q}) &&
               ({1'b0, i_vcount} <  ({1'b0, y_q} + BOX_H13));
  end

  // Next position, direction and colour; walls reverse direction and step back inward
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    col_d      = col_q;
    bounce_x_s = 1'b0;
    bounce_y_s = 1'b0;
    move_s     = event_s & ~pause_s;
    if (move_s) begin
      if (dx_q) begin
        if (x_q == X_MAX) begin
          dx_d = 1'b0; x_d = x_q - 12'd1; bounce_x_s = 1'b1;
        end else begin
          x_d = x_q + 12'd1;
        end
      end else begin
        if (x_q == 12'd0) begin
          dx_d = 1'b1; x_d = 12'd1; bounce_x_s = 1'b1;
        end else begin
          x_d = x_q - 12'd1;
        end
      end
      if (dy_q) begin
        if (y_q == Y_MAX) begin
          dy_d = 1'b0; y_d = y_q - 12'd1; bounce_y_s = 1'b1;
        end else begin
          y_d = y_q + 12'd1;
        end
      end else begin
        if (y_q == 12'd0) begin
          dy_d = 1'b1; y_d = 12'd1; bounce_y_s = 1'b1;
        end else begin
          y_d = y_q - 12'd1;
        end
      end
      // A corner hit advances the colour only once; colour skips 0 (black)
      if (bounce_x_s || bounce_y_s) begin
        col_d = (col_q == 3'd7) ? 3'd1 : col_q + 3'd1;
      end else begin
        col_d = col_q;
      end
    end else begin
      move_s = 1'b0;
    end
  end

  // Two-stage pixel pipeline feeding the output pins
  always_comb begin
    s1_inside_d = inside_s & i_enable;
    s1_hsync_d  = i_hsync;
    s1_vsync_d  = i_vsync;
    s1_event_d  = event_s;
    rgb_d       = s1_inside_q ? col_q : 3'b000;
    hsync_d     = s1_hsync_q;
    vsync_d     = s1_vsync_q;
    frame_d     = s1_event_q;
  end

  // State and pipeline registers; syncs reset to their inactive (high) level
  always_ff @(posedge i_pixclock or posedge i_reset) begin
    if (i_reset) begin
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      col_q       <= 3'b111;
      s1_inside_q <= 1'b0;
      s1_hsync_q  <= 1'b1;
      s1_vsync_q  <= 1'b1;
      s1_event_q  <= 1'b0;
      rgb_q       <= 3'b000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      col_q       <= col_d;
      s1_inside_q <= s1_inside_d;
      s1_hsync_q  <= s1_hsync_d;
      s1_vsync_q  <= s1_vsync_d;
      s1_event_q  <= s1_event_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_q     <= frame_d;
    end
  end

  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_red   = rgb_q[2];
  assign o_green = rgb_q[1];
  assign o_blue  = rgb_q[0];
  assign o_frame = frame_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Self-checking bench for vga_bounce_box with a small screen (64x48, 8x8 box).
// The reference model derives the box position from the number of moves as a
// triangle wave and the colour from the count of bounce events.
module tb_vga_bounce_box;

  localparam int HPIX = 64;
  localparam int VPIX = 48;
  localparam int BW   = 8;
  localparam int BH   = 8;
  localparam int XM   = HPIX - BW;
  localparam int YM   = VPIX - BH;

  logic        clk;
  logic        rst;
  logic [11:0] hcount, vcount;
  logic        enable, hsync, vsync;
`ifdef BOUNCE_PAUSE_EN
  logic        pause;
`endif
  logic        o_hsync, o_vsync, o_red, o_green, o_blue, o_frame;

  int total;
  int passed;
  int moves;

  vga_bounce_box #(.HPIX(HPIX), .VPIX(VPIX), .BOX_W(BW), .BOX_H(BH)) dut (
    .i_pixclock(clk),
    .i_reset   (rst),
    .i_hcount  (hcount),
    .i_vcount  (vcount),
    .i_enable  (enable),
    .i_hsync   (hsync),
    .i_vsync   (vsync),
`ifdef BOUNCE_PAUSE_EN
    .i_pause   (pause),
`endif
    .o_hsync   (o_hsync),
    .o_vsync   (o_vsync),
    .o_red     (o_red),
    .o_green   (o_green),
    .o_blue    (o_blue),
    .o_frame   (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        en;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
  } vec_t;

  vec_t tbl [6];

  // ---------------- reference model ----------------
  function automatic int tri_pos(input int n, input int m);
    int p;
    p = n % (2 * m);
    return (p <= m) ? p : (2 * m - p);
  endfunction

  // Event k reverses an axis when the position before it sits on a wall,
  // i.e. when k-1 is a positive multiple of that axis' travel range.
  function automatic logic [2:0] model_col(input int n);
    int b;
    b = 0;
    for (int k = 1; k <= n; k++) begin
      if ((k - 1) > 0 && (((k - 1) % XM) == 0 || ((k - 1) % YM) == 0)) b++;
    end
    if (b == 0) return 3'd7;
    return 3'(((b - 1) % 7) + 1);
  endfunction

  function automatic logic [2:0] model_rgb(input logic [11:0] h, input logic [11:0] v, input logic en);
    int x, y, hi, vi;
    x  = tri_pos(moves, XM);
    y  = tri_pos(moves, YM);
    hi = int'(h);
    vi = int'(v);
    if (en && hi >= x && hi < x + BW && vi >= y && vi < y + BH) return model_col(moves);
    return 3'b000;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [11:0] h, input logic [11:0] v, input logic en,
                        input logic hs, input logic vs);
    hcount = h; vcount = v; enable = en; hsync = hs; vsync = vs;
  endtask

  task automatic set_idle();
    set_in(12'd1, 12'd1, 1'b0, 1'b1, 1'b1);
  endtask

  // Present one pixel, then idle; outputs sampled two edges later
  task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic en,
                     input logic hs, input logic vs,
                     output logic [2:0] rgb, output logic ohs, output logic ovs);
    set_in(h, v, en, hs, vs);
    tick();
    set_idle();
    tick();
    rgb = {o_red, o_green, o_blue};
    ohs = o_hsync;
    ovs = o_vsync;
  endtask

  task automatic probe(input string name, input logic [11:0] h, input logic [11:0] v,
                       input logic [2:0] exp);
    logic [2:0] rgb;
    logic ohs, ovs;
    pix(h, v, 1'b1, 1'b1, 1'b1, rgb, ohs, ovs);
    chk(name, {29'd0, rgb}, {29'd0, exp});
  endtask

  task automatic frame(input logic pz);
`ifdef BOUNCE_PAUSE_EN
    pause = pz;
`endif
    set_in(12'd0, 12'(VPIX), 1'b0, 1'b1, 1'b1);
    tick();
`ifdef BOUNCE_PAUSE_EN
    pause = 1'b0;
`endif
    set_idle();
    tick();
    chk("frame_pulse", {31'd0, o_frame}, 32'd1);
    tick();
    chk("frame_single", {31'd0, o_frame}, 32'd0);
    if (!pz) moves++;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [2:0] rgb;
    logic ohs, ovs;
    int hi, vi;
    logic [11:0] h12, v12;
    logic en, hs, vs;

    total = 0; passed = 0; moves = 0;
    rst = 1'b1;
`ifdef BOUNCE_PAUSE_EN
    pause = 1'b0;
`endif
    set_idle();

    // Vectors at the reset position (x=0,y=0,colour 7)
    tbl[0] = '{h: 12'd0,  v: 12'd0, en: 1'b1, hs: 1'b0, vs: 1'b1, rgb: 3'b111};
    tbl[1] = '{h: 12'd8,  v: 12'd0, en: 1'b1, hs: 1'b1, vs: 1'b0, rgb: 3'b000};
    tbl[2] = '{h: 12'd7,  v: 12'd7, en: 1'b1, hs: 1'b0, vs: 1'b0, rgb: 3'b111};
    tbl[3] = '{h: 12'd7,  v: 12'd8, en: 1'b1, hs: 1'b1, vs: 1'b1, rgb: 3'b000};
    tbl[4] = '{h: 12'd3,  v: 12'd3, en: 1'b0, hs: 1'b1, vs: 1'b0, rgb: 3'b000};
    tbl[5] = '{h: 12'd0,  v: 12'd8, en: 1'b1, hs: 1'b0, vs: 1'b1, rgb: 3'b000};

    tick(); tick();
    rst = 1'b0;
    tick();

    // Fill the pipeline with a drawn pixel and low syncs, then reset mid-line
    set_in(12'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("pre_reset_rgb", {29'd0, o_red, o_green, o_blue}, 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("rst_hsync", {31'd0, o_hsync}, 32'd1);
    chk("rst_vsync", {31'd0, o_vsync}, 32'd1);
    chk("rst_rgb",   {29'd0, o_red, o_green, o_blue}, 32'd0);
    chk("rst_frame", {31'd0, o_frame}, 32'd0);
    set_idle();
    tick();
    rst = 1'b0;
    tick();

    // Sync latency: low at edge n shows on the output after edge n+2
    hsync = 1'b0;
    tick();
    chk("hsync_lat1", {31'd0, o_hsync}, 32'd1);
    hsync = 1'b1;
    tick();
    chk("hsync_lat2", {31'd0, o_hsync}, 32'd0);
    tick();
    chk("hsync_lat3", {31'd0, o_hsync}, 32'd1);

    // Table-driven draw/latency vectors
    for (int i = 0; i < 6; i++) begin
      pix(tbl[i].h, tbl[i].v, tbl[i].en, tbl[i].hs, tbl[i].vs, rgb, ohs, ovs);
      chk($sformatf("tbl%0d_rgb", i), {29'd0, rgb}, {29'd0, tbl[i].rgb});
      chk($sformatf("tbl%0d_hs", i), {31'd0, ohs}, {31'd0, tbl[i].hs});
      chk($sformatf("tbl%0d_vs", i), {31'd0, ovs}, {31'd0, tbl[i].vs});
    end

    // Skipped event: counters never hit (0,VPIX) -> no move, no pulse
    set_in(12'd1, 12'(VPIX), 1'b0, 1'b1, 1'b1);
    tick(); set_idle(); tick();
    chk("skip_no_frame", {31'd0, o_frame}, 32'd0);
    probe("skip_pos", 12'd0, 12'd0, 3'b111);

    // Run frames with wall/corner checkpoints and randomized probes
    for (int f = 1; f <= 290; f++) begin
      frame(1'b0);
      if (f == 56) begin
        probe("f56_x56", 12'd56, 12'd24, 3'd1);
        probe("f56_x55", 12'd55, 12'd24, 3'd0);
      end
      if (f == 57) begin
        probe("f57_x55", 12'd55, 12'd23, 3'd2);
        probe("f57_x62", 12'd62, 12'd23, 3'd2);
        probe("f57_x63", 12'd63, 12'd23, 3'd0);
      end
      if (f == 113) begin
        probe("f113_x0", 12'd0, 12'd33, 3'd0);
        probe("f113_x1", 12'd1, 12'd33, 3'd4);
        probe("f113_x8", 12'd8, 12'd33, 3'd4);
      end
      if (f == 280) probe("f280_corner", 12'd56, 12'd40, 3'd3);
      if (f == 281) begin
        probe("f281_after", 12'd55, 12'd39, 3'd4);
        probe("f281_edge", 12'd63, 12'd47, 3'd0);
      end
      for (int r = 0; r < 3; r++) begin
        hi  = tri_pos(moves, XM) + int'($urandom_range(0, BW + 1)) - 1;
        vi  = tri_pos(moves, YM) + int'($urandom_range(0, BH + 1)) - 1;
        h12 = 12'(hi);
        v12 = 12'(vi);
        en  = ($urandom_range(0, 3) != 0);
        hs  = 1'($urandom_range(0, 1));
        vs  = 1'($urandom_range(0, 1));
        pix(h12, v12, en, hs, vs, rgb, ohs, ovs);
        chk($sformatf("rand_f%0d_rgb(%0d,%0d)", f, hi, vi), {29'd0, rgb},
            {29'd0, model_rgb(h12, v12, en)});
        chk("rand_hs", {31'd0, ohs}, {31'd0, hs});
        chk("rand_vs", {31'd0, ovs}, {31'd0, vs});
      end
    end

`ifdef BOUNCE_PAUSE_EN
    // Pause across 3 events: position and colour held, o_frame still pulses
    for (int p = 0; p < 3; p++) begin
      frame(1'b1);
      probe("pause_hold", 12'(tri_pos(moves, XM)), 12'(tri_pos(moves, YM)), model_col(moves));
    end
    frame(1'b0);
    probe("pause_resume", 12'(tri_pos(moves, XM)), 12'(tri_pos(moves, YM)), model_col(moves));
    probe("pause_resume_old", 12'(tri_pos(moves - 1, XM) + BW - 1),
          12'(tri_pos(moves, YM)), model_rgb(12'(tri_pos(moves - 1, XM) + BW - 1),
                                             12'(tri_pos(moves, YM)), 1'b1));
`endif

    // Reset mid-frame: box returns to the origin with colour 7
    set_in(12'd20, 12'd10, 1'b1, 1'b1, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_rgb", {29'd0, o_red, o_green, o_blue}, 32'd0);
    tick();
    rst = 1'b0;
    moves = 0;
    probe("midrst_origin", 12'd0, 12'd0, 3'b111);
    probe("midrst_out", 12'd8, 12'd8, 3'b000);
    frame(1'b0);
    probe("midrst_move", 12'd1, 12'd1, model_rgb(12'd1, 12'd1, 1'b1));
    probe("midrst_left", 12'd0, 12'd1, model_rgb(12'd0, 12'd1, 1'b1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
